hilo_muldiv_unit: RTL and testbench

//  Sequential unsigned multiply/divide unit that produces the HI/LO register pair.
//  It is the producer end of the HiOut/LoOut path that the result-select MUX reads
//  for MFHI/MFLO. Ops are selected by the same 6-bit function code.
//  A MULTU or DIVU is launched with start; the result is written to HI/LO after a fixed latency.

---
 rtl/hilo_muldiv_unit_if.sv | 24 ++
 rtl/hilo_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Operand/result bundle between the issuing pipeline and the HI/LO mul/div unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             busy;
  logic             done;

  modport master (
    output start, Signal, dataA, dataB,
    input  HiOut, LoOut, busy, done
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output HiOut, LoOut, busy, done
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Sequential unsigned MULTU/DIVU unit that produces the HI/LO register pair.
// Define HILO_DIVU_EN to build the restoring divider and the DIVU decode.
module hilo_muldiv_unit #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] MULTU = 6'b011001
`ifdef HILO_DIVU_EN
  , parameter logic [5:0] DIVU = 6'b011011
`endif
) (
  input logic              clk,
  input logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
`ifdef HILO_DIVU_EN
    , DIV = 2'd3
`endif
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0] operand;
  logic             mulStart;
  logic             divStart;
  logic             load;
  logic             loadMul;
  logic             iterate;
  logic             finish;
  logic [WIDTH:0]   mulSum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // The counter runs WIDTH-1 down past zero; its MSB going high marks the
  // edge after the last iteration, which is the DONE entry edge.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    loadMul   = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    mulStart  = bus.start && (bus.Signal == MULTU);
`ifdef HILO_DIVU_EN
    divStart  = bus.start && (bus.Signal == DIVU);
`else
    divStart  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        nextState = IDLE;
        if (mulStart) begin
          nextState = MUL;
          load      = 1'b1;
          loadMul   = 1'b1;
        end
`ifdef HILO_DIVU_EN
        else if (divStart) begin
          nextState = DIV;
          load      = 1'b1;
        end
`endif
      end
      MUL
`ifdef HILO_DIVU_EN
      , DIV
`endif
      : begin
        if (cnt[CW-1]) begin
          nextState = DONE;
          finish    = 1'b1;
        end else begin
          iterate = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Shared accumulator: {partial product, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV, so HI/LO map identically.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    accNext = {mulSum, acc[WIDTH-1:1]};
`ifdef HILO_DIVU_EN
    if (state == DIV) begin
      // A zero divisor always "fits", which leaves the dividend in HI and all ones in LO.
      if (acc[2*WIDTH-1:WIDTH-1] >= {1'b0, operand})
        accNext = {acc[2*WIDTH-2:WIDTH-1] - operand, acc[WIDTH-2:0], 1'b1};
      else
        accNext = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      operand   <= '0;
      cnt       <= '0;
      bus.HiOut <= '0;
      bus.LoOut <= '0;
    end else begin
      if (load) begin
        operand <= loadMul ? bus.dataA : bus.dataB;
        acc     <= {{WIDTH{1'b0}}, (loadMul ? bus.dataB : bus.dataA)};
        cnt     <= CW'(WIDTH - 1);
      end else if (iterate) begin
        acc <= accNext;
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        bus.HiOut <= acc[2*WIDTH-1:WIDTH];
        bus.LoOut <= acc[WIDTH-1:0];
      end
    end
  end

`ifdef HILO_DIVU_EN
  assign bus.busy = (state == MUL) || (state == DIV);
`else
  assign bus.busy = (state == MUL);
`endif
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed ops push expected HI/LO and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] ADD   = 6'b100000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCycle;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int   edgeCount = 0;
  int   total     = 0;
  int   bad       = 0;
  int   lastStart = 0;
  int   busyCnt;
  int   doneCnt;
  int   waitCnt;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        mon = sb.pop_front();
        checkOutput({mon.tag, "_hi"}, 64'(bus.HiOut), 64'(mon.hi));
        checkOutput({mon.tag, "_lo"}, 64'(bus.LoOut), 64'(mon.lo));
        checkOutput({mon.tag, "_cycle"}, 64'(edgeCount), 64'(mon.doneCycle));
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] sig, input logic [31:0] a,
                               input logic [31:0] b, input bit accept,
                               input bit expBusy, input logic [31:0] expHi,
                               input logic [31:0] expLo, input string tag);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Signal = sig;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    #1;
    lastStart = edgeCount;
    if (accept) sb.push_back('{expHi, expLo, edgeCount + 33, tag});
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(expBusy));
    bus.start = 1'b0;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start  = 1'b0;
    bus.Signal = '0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", 64'(bus.HiOut), 64'd0);
    checkOutput("reset_lo", 64'(bus.LoOut), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(MULTU, 32'd3, 32'd5, 1'b1, 1'b1, 32'd0, 32'd15, "mul_3x5");
    waitDrain(60);

    // Largest operands; inputs scrambled while busy must not disturb the product.
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
                  32'hFFFF_FFFE, 32'h0000_0001, "mul_max");
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.dataA = $urandom;
      bus.dataB = $urandom;
      if (bus.busy) busyCnt++;
      if (bus.done) doneCnt++;
    end
    checkOutput("mul_max_busy_cycles", 64'(busyCnt), 64'd32);
    checkOutput("mul_max_done_cycles", 64'(doneCnt), 64'd1);
    waitDrain(10);

    applyStimulus(MULTU, 32'd2, 32'd3, 1'b1, 1'b1, 32'd0, 32'd6, "mul_2x3");
    repeat (9) @(posedge clk);
    #1;
    checkOutput("hold_hi", 64'(bus.HiOut), 64'hFFFF_FFFE);
    checkOutput("hold_lo", 64'(bus.LoOut), 64'h1);
    applyStimulus(MULTU, 32'd7, 32'd7, 1'b0, 1'b1, 32'd0, 32'd0, "mul_7x7_busy");
    waitDrain(60);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("after_ignored_lo", 64'(bus.LoOut), 64'd6);

    applyStimulus(MULTU, 32'd9, 32'd9, 1'b0, 1'b1, 32'd0, 32'd0, "mul_9x9");
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_hi", 64'(bus.HiOut), 64'd0);
    checkOutput("abort_lo", 64'(bus.LoOut), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("post_abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("post_abort_lo", 64'(bus.LoOut), 64'd0);

`ifdef HILO_DIVU_EN
    applyStimulus(DIVU, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14, "div_100_7");
    waitDrain(60);
    applyStimulus(DIVU, 32'h0000_1234, 32'd0, 1'b1, 1'b1,
                  32'h0000_1234, 32'hFFFF_FFFF, "div_by_zero");
    waitDrain(60);
`endif

    applyStimulus(MULTU, 32'h1234_5678, 32'h10, 1'b1, 1'b1,
                  32'h1, 32'h2345_6780, "mul_pre");
    waitDrain(60);
    applyStimulus(ADD, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, "add_ignored");
`ifndef HILO_DIVU_EN
    applyStimulus(DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, "divu_disabled");
`endif
    repeat (40) @(posedge clk);
    #1;
    checkOutput("ignored_hi", 64'(bus.HiOut), 64'h1);
    checkOutput("ignored_lo", 64'(bus.LoOut), 64'h2345_6780);
    checkOutput("ignored_busy", 64'(bus.busy), 64'd0);

    // Second launch lands on the DONE edge of the first.
    applyStimulus(MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1,
                  32'h1, 32'h0, "b2b_first");
    waitCnt = 0;
    while (bus.done !== 1'b1 && waitCnt < 60) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (bus.done !== 1'b1) checkOutput("b2b_timeout", 64'(bus.done), 64'd1);
    applyStimulus(MULTU, 32'hDEAD_BEEF, 32'd2, 1'b1, 1'b1,
                  32'h1, 32'hBD5B_7DDE, "b2b_second");
    waitDrain(60);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
